// File: rtl/iommu_reg_pkg.sv
// Shared types and helpers for the IOMMU register access front-end.
package iommu_reg_pkg;

  localparam int REG_DW     = 32;
  localparam int REG_SW     = REG_DW / 8;
  localparam int WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [REG_DW-1:0] strb2mask(input logic [REG_SW-1:0] strb);
    logic [REG_DW-1:0] mask;
    for (int b = 0; b < REG_SW; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/iommu_reg_decode.sv
// Combinational byte-address to register-slot decoder (one-hot, binary, error).
module iommu_reg_decode
  import iommu_reg_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_REGS-1:0]   onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] word;

  always_comb begin
    word   = addr >> WORD_SHIFT;
    idx    = word[IDX_W-1:0];
    err    = (addr[WORD_SHIFT-1:0] != '0) || (word >= ADDR_WIDTH'(NUM_REGS));
    onehot = err ? '0 : (NUM_REGS'(1) << idx);
  end

endmodule

// File: rtl/iommu_reg_access.sv
// IOMMU register-interface front-end: request decode, SW strobes, merged writes, response.
// Optional write lock via macro IOMMU_REG_ACCESS_LOCK_EN (adds LOCK_MASK and lock_i).
module iommu_reg_access
  import iommu_reg_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
`ifdef IOMMU_REG_ACCESS_LOCK_EN
  , parameter logic [NUM_REGS-1:0] LOCK_MASK = '0
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
`ifdef IOMMU_REG_ACCESS_LOCK_EN
  input  logic                           lock_i,
`endif
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_write_i,
  input  logic [ADDR_WIDTH-1:0]          req_addr_i,
  input  logic [DATA_WIDTH-1:0]          req_wdata_i,
  input  logic [STRB_WIDTH-1:0]          req_wstrb_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           rsp_error_o,
  output logic [NUM_REGS-1:0]            reg_we_o,
  output logic [DATA_WIDTH-1:0]          reg_wd_o,
  output logic [NUM_REGS-1:0]            reg_re_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_qs_i
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e state_q, state_d;

  logic                  write_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [STRB_WIDTH-1:0] wstrb_p0;

  logic [NUM_REGS-1:0]   dec_onehot;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  lock_err;
  logic [DATA_WIDTH-1:0] qs_sel;
  logic [DATA_WIDTH-1:0] mask;

  logic [NUM_REGS-1:0]   we_d, re_d;
  logic [DATA_WIDTH-1:0] wd_d, rdata_d;
  logic                  err_d;

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);

  // Stage p0: request capture on handshake
  always_ff @(posedge clk_i) begin
    if (req_valid_i && req_ready_o) begin
      write_p0 <= req_write_i;
      addr_p0  <= req_addr_i;
      wdata_p0 <= req_wdata_i;
      wstrb_p0 <= req_wstrb_i;
    end
  end

  iommu_reg_decode #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr  (addr_p0),
    .onehot(dec_onehot),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  assign qs_sel = reg_qs_i[DATA_WIDTH*dec_idx +: DATA_WIDTH];
  assign mask   = strb2mask(wstrb_p0);

`ifdef IOMMU_REG_ACCESS_LOCK_EN
  assign lock_err = write_p0 && !dec_err && lock_i && LOCK_MASK[dec_idx];
`else
  assign lock_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = '0;
    re_d    = '0;
    wd_d    = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:   if (req_valid_i) state_d = ACCESS;
      ACCESS: begin
        state_d = RESP;
        err_d   = dec_err || lock_err;
        if (!err_d) begin
          if (write_p0) begin
            if (wstrb_p0 != '0) begin
              we_d = dec_onehot;
              wd_d = (wdata_p0 & mask) | (qs_sel & ~mask);
            end
          end else begin
            re_d    = dec_onehot;
            rdata_d = qs_sel;
          end
        end
      end
      RESP:   if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered strobes and held response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      reg_we_o    <= '0;
      reg_re_o    <= '0;
      reg_wd_o    <= '0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_we_o <= we_d;
      reg_re_o <= re_d;
      reg_wd_o <= wd_d;
      if (state_q == ACCESS) begin
        rsp_rdata_o <= rdata_d;
        rsp_error_o <= err_d;
      end
    end
  end

endmodule

// File: doc/iommu_reg_access.md
Name: iommu_reg_access

Overview:
Register-interface front-end that sits directly upstream of the IOMMU register field instances. It accepts single-beat requests on a valid/ready bus and decodes the address to a register index. It drives per-register SW write-enable, write-data and read-pulse strobes into the field array, then returns read data and an error flag on a valid/ready response channel. Partial writes are merged with current field contents so every field always sees a full-width write.

Parameters:
NUM_REGS, 16, number of 32-bit register slots; slot i at byte offset 4*i
ADDR_WIDTH, 12, request byte-address width
DATA_WIDTH, 32, register and bus data width; fixed to 32
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid and ready are both high
req_write_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  write data
req_wstrb_i  in  STRB_WIDTH  byte strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_WIDTH  read data; 0 on writes and errors
rsp_error_o  out  1  decode error
reg_we_o  out  NUM_REGS  one-hot SW write enable to fields
reg_wd_o  out  DATA_WIDTH  merged SW write data, shared by all fields
reg_re_o  out  NUM_REGS  one-hot read pulse, used for RC fields
reg_qs_i  in  NUM_REGS*DATA_WIDTH  field SW read ports; slot i occupies bits [32i+31:32i]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values of outputs: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, reg_we_o=0, reg_re_o=0, reg_wd_o=0.
- IDLE: req_ready_o=1. On handshake, capture write, addr, wdata and wstrb; go to ACCESS.
- ACCESS (exactly 1 cycle): req_ready_o=0.
  - Decode error if addr[1:0]!=0 or addr[ADDR_WIDTH-1:2]>=NUM_REGS.
  - Valid write: reg_we_o[idx]=1 only if wstrb!=0.
  - reg_wd_o = (wdata & M) | (qs[idx] & ~M), where M expands each strobe bit to a byte.
  - Write with wstrb=0: no write enable, OK response.
  - Valid read: reg_re_o[idx]=1. Capture qs[idx] in the same cycle, so the pre-clear value of an RC field is returned.
  - Error: no we or re pulse; rdata=0, error=1.
  - Go to RESP.
- RESP: rsp_valid_o=1 with rdata and error held stable until rsp_ready_i; then return to IDLE, rsp_valid_o=0.
- Latency: request accept to rsp_valid_o is 2 cycles. Maximum throughput is one request per 3 cycles with rsp_ready_i tied high.
- No overlapping requests; req_ready_o=0 in ACCESS and RESP.
- reg_we_o and reg_re_o are registered, 1-cycle pulses, and never both non-zero.
- reg_wd_o is 0 whenever reg_we_o=0.
- Reset mid-transaction: return to IDLE immediately; the pending response is dropped and no strobe is emitted.

Optional Feature:
Macro IOMMU_REG_ACCESS_LOCK_EN.
- Defined:
  - Adds parameter LOCK_MASK (NUM_REGS bits, default 0) and input lock_i (1 bit).
  - A valid write to slot i with LOCK_MASK[i]=1 while lock_i=1 (sampled in ACCESS) emits no reg_we_o and responds error=1. Reads are unaffected.
- Undefined: no lock_i port, no LOCK_MASK parameter, no lock check.

Decomposition:
- Package iommu_reg_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - the function strb2mask(STRB_WIDTH)->DATA_WIDTH;
  - the localparam for the word-offset shift (2).
- Sub-module iommu_reg_decode, combinational: takes addr and NUM_REGS; outputs one-hot index, binary index and error. Instantiated once.

Test Plan:
- Reset then write addr 0x008, wdata 0xDEADBEEF, wstrb 0xF -> two cycles after accept, reg_we_o=0x0004 and reg_wd_o=0xDEADBEEF for 1 cycle; rsp error=0, rdata=0.
- qs[3]=0x11223344; write addr 0x00C, wdata 0xAABBCCDD, wstrb 0x5 -> reg_wd_o=0x11BB33DD.
- qs[1]=0x5A5A5A5A; read 0x004 -> reg_re_o=0x0002 pulse; rsp rdata=0x5A5A5A5A. An RC field clearing on the pulse still returns the pre-clear value.
- Read 0x040 (NUM_REGS=16) and write 0x006 -> no strobes; each response error=1, rdata=0.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rdata stay stable; req_ready_o=0 throughout; rsp_ready_i=1 returns to IDLE.
- Assert rst_ni low during ACCESS -> all outputs reach reset values asynchronously; no we pulse after reset release.
